// File: rtl/gate_seq_pkg.sv
// Shared definitions for the gate-unit test sequencer: FSM encoding, vector count and
// the reference gate function the sequencer checks results against.
package gate_seq_pkg;

  typedef enum logic [1:0] {StIdle, StApply, StCheck, StDone} state_e;

  localparam int unsigned NUM_VEC = 4;

  // Expected {And, Or, Not} for a given operand pair.
  function automatic logic [2:0] expected_gates(input logic a, input logic b);
    return {a & b, a | b, ~a};
  endfunction

endpackage

// File: rtl/gate_seq_timer.sv
// Dwell down-counter: loads a non-zero hold time, counts to zero and never wraps.
// tc is high in the last cycle of the dwell window.
module gate_seq_timer #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  output logic               tc
);

  logic [DWELL_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign tc = (cnt_q == DWELL_W'(1));

endmodule

// File: rtl/gate_seq_ctrl.sv
// Sequencer that walks an external gate unit through all four operand pairs and reports a
// verdict. Define GATE_SEQ_ERRLOG_EN to capture the first failing vector and its mismatch mask.
module gate_seq_ctrl #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               iClk,
  input  logic               iRst,
  input  logic               iStart,
  input  logic [DWELL_W-1:0] iDwell,
  output logic               oA,
  output logic               oB,
  input  logic               iAnd,
  input  logic               iOr,
  input  logic               iNot,
  output logic               oBusy,
  output logic               oDone,
  output logic               oPass,
  output logic [1:0]         oVecIdx,
  output logic [1:0]         oErrVec,
  output logic [2:0]         oErrBits
);

  import gate_seq_pkg::*;

  state_e             state_q;
  logic [1:0]         vec_q;
  logic [1:0]         vec_nxt;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] start_dwell;
  logic [DWELL_W-1:0] load_val;
  logic               fail_q;
  logic               last_vec;
  logic               accept;
  logic               load;
  logic               tc;
  logic [2:0]         mism;

  // A zero dwell would never reach terminal count; treat it as one cycle.
  assign start_dwell = (iDwell == '0) ? DWELL_W'(1) : iDwell;
  assign last_vec    = (vec_q == 2'(NUM_VEC - 1));
  assign vec_nxt     = vec_q + 2'd1;
  assign accept      = (state_q == StIdle) && iStart;
  assign load        = accept || ((state_q == StCheck) && !last_vec);
  assign load_val    = (state_q == StIdle) ? start_dwell : dwell_q;
  assign mism        = {iAnd, iOr, iNot} ^ expected_gates(oA, oB);
  assign oVecIdx     = vec_q;

  gate_seq_timer #(
    .DWELL_W(DWELL_W)
  ) u_timer (
    .clk     (iClk),
    .rst     (iRst),
    .load    (load),
    .load_val(load_val),
    .tc      (tc)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      dwell_q <= '0;
      fail_q  <= 1'b0;
      oA      <= 1'b0;
      oB      <= 1'b0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oPass   <= 1'b0;
    end else begin
      oDone <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (iStart) begin
            state_q <= StApply;
            vec_q   <= '0;
            dwell_q <= start_dwell;
            fail_q  <= 1'b0;
            oPass   <= 1'b0;
            oA      <= 1'b0;
            oB      <= 1'b0;
            oBusy   <= 1'b1;
          end
        end
        StApply: begin
          if (tc) state_q <= StCheck;
        end
        StCheck: begin
          if (mism != '0) fail_q <= 1'b1;
          if (last_vec) begin
            state_q <= StDone;
            vec_q   <= '0;
            oA      <= 1'b0;
            oB      <= 1'b0;
            oBusy   <= 1'b0;
            oDone   <= 1'b1;
            oPass   <= !(fail_q || (mism != '0));
          end else begin
            state_q <= StApply;
            vec_q   <= vec_nxt;
            oA      <= vec_nxt[0];
            oB      <= vec_nxt[1];
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef GATE_SEQ_ERRLOG_EN
  logic [1:0] err_vec_q;
  logic [2:0] err_bits_q;

  // Only the first mismatch of a run is logged; fail_q marks that one was already seen.
  always_ff @(posedge iClk) begin
    if (iRst || accept) begin
      err_vec_q  <= '0;
      err_bits_q <= '0;
    end else if ((state_q == StCheck) && (mism != '0) && !fail_q) begin
      err_vec_q  <= vec_q;
      err_bits_q <= mism;
    end
  end

  assign oErrVec  = err_vec_q;
  assign oErrBits = err_bits_q;
`else
  assign oErrVec  = '0;
  assign oErrBits = '0;
`endif

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Scoreboard bench for gate_seq_ctrl: runs are queued with hand-computed verdicts and a
// negedge monitor checks the applied vector sequence and each DONE report.
module tb_gate_seq_ctrl;

  localparam int unsigned DW = 4;

  typedef struct {
    int d;
    int done_cyc;
    int pass;
    int err_vec;
    int err_bits;
  } exp_t;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iStart;
  logic [DW-1:0] iDwell;
  logic          oA, oB, iAnd, iOr, iNot;
  logic          oBusy, oDone, oPass;
  logic [1:0]    oVecIdx, oErrVec;
  logic [2:0]    oErrBits;
  logic          fault_and, fault_not;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   start_cyc   = 0;
  int   busy_cnt    = 0;

  gate_seq_ctrl #(
    .DWELL_W(DW)
  ) dut (
    .iClk    (iClk),
    .iRst    (iRst),
    .iStart  (iStart),
    .iDwell  (iDwell),
    .oA      (oA),
    .oB      (oB),
    .iAnd    (iAnd),
    .iOr     (iOr),
    .iNot    (iNot),
    .oBusy   (oBusy),
    .oDone   (oDone),
    .oPass   (oPass),
    .oVecIdx (oVecIdx),
    .oErrVec (oErrVec),
    .oErrBits(oErrBits)
  );

  // External gate unit with optional faults.
  assign iAnd = fault_and ? 1'b0 : (oA & oB);
  assign iOr  = oA | oB;
  assign iNot = fault_not ? oA : ~oA;

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(negedge iClk) begin : monitor
    exp_t e;
    int   idx;
    if (oBusy && sb.size() > 0) begin
      idx = busy_cnt / (sb[0].d + 1);
      check("vec_idx", 32'(oVecIdx), idx);
      check("op_a", 32'(oA), idx % 2);
      check("op_b", 32'(oB), idx / 2);
      busy_cnt++;
    end
    if (oDone) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(oDone), 0);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc - start_cyc + 1, e.done_cyc);
        check("pass", 32'(oPass), e.pass);
        check("err_vec", 32'(oErrVec), e.err_vec);
        check("err_bits", 32'(oErrBits), e.err_bits);
        check("busy_at_done", 32'(oBusy), 0);
        check("busy_cycles", busy_cnt, 4 * (e.d + 1));
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge iClk);
    #1;
  endtask

  // ev/eb are the logged values when the error log is built in.
  task automatic start_run(input int dwell, input bit push, input int pass, input int ev,
                           input int eb);
    exp_t e;
    int   d;
    d = (dwell == 0) ? 1 : dwell;
    if (push) begin
      e.d        = d;
      e.done_cyc = 4 * (d + 1) + 1;
      e.pass     = pass;
`ifdef GATE_SEQ_ERRLOG_EN
      e.err_vec  = ev;
      e.err_bits = eb;
`else
      e.err_vec  = 0;
      e.err_bits = 0;
`endif
      sb.push_back(e);
    end
    @(negedge iClk);
    iDwell = DW'(dwell);
    iStart = 1'b1;
    @(posedge iClk);
    #1;
    iStart    = 1'b0;
    start_cyc = cyc;
    check("pass_cleared_on_start", 32'(oPass), 0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(posedge iClk);
      n++;
    end
    if (sb.size() > 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
      busy_cnt = 0;
    end
    wait_cycles(1);
  endtask

  initial begin
    iRst      = 1'b1;
    iStart    = 1'b0;
    iDwell    = '0;
    fault_and = 1'b0;
    fault_not = 1'b0;
    wait_cycles(3);
    check("rst_a", 32'(oA), 0);
    check("rst_b", 32'(oB), 0);
    check("rst_busy", 32'(oBusy), 0);
    check("rst_done", 32'(oDone), 0);
    check("rst_pass", 32'(oPass), 0);
    check("rst_vec_idx", 32'(oVecIdx), 0);
    check("rst_err_vec", 32'(oErrVec), 0);
    check("rst_err_bits", 32'(oErrBits), 0);
    iRst = 1'b0;
    wait_cycles(2);

    // Good gate unit, dwell 3: DONE at cycle 17.
    start_run(3, 1'b1, 1, 0, 0);
    wait_done(100);
    wait_cycles(3);
    check("pass_held", 32'(oPass), 1);

    // Dwell 0 behaves as 1: DONE at cycle 9.
    start_run(0, 1'b1, 1, 0, 0);
    wait_done(100);

    // And stuck at 0: only vector 3 (A=B=1) mismatches.
    fault_and = 1'b1;
    start_run(2, 1'b1, 0, 3, 3'b100);
    wait_done(100);
    fault_and = 1'b0;

    // Not inverted: every vector mismatches, first at vector 0.
    fault_not = 1'b1;
    start_run(1, 1'b1, 0, 0, 3'b001);
    wait_done(100);
    fault_not = 1'b0;

    // Maximum dwell held exactly; log from the previous run is cleared.
    start_run(15, 1'b1, 1, 0, 0);
    wait_done(200);

    // Starts during the run (cycle 5) and in the DONE cycle (9) are ignored.
    start_run(1, 1'b1, 1, 0, 0);
    wait_cycles(4);
    iStart = 1'b1;
    wait_cycles(1);
    iStart = 1'b0;
    wait_cycles(3);
    iStart = 1'b1;
    wait_cycles(1);
    iStart = 1'b0;
    check("no_restart_busy", 32'(oBusy), 0);
    wait_done(10);
    wait_cycles(20);
    check("no_restart_idle", 32'(oBusy), 0);

    // Reset during vector 2 APPLY (cycles 7-8 for dwell 2) aborts the run.
    start_run(2, 1'b0, 0, 0, 0);
    wait_cycles(6);
    iRst = 1'b1;
    wait_cycles(1);
    iRst = 1'b0;
    check("abort_a", 32'(oA), 0);
    check("abort_b", 32'(oB), 0);
    check("abort_busy", 32'(oBusy), 0);
    check("abort_pass", 32'(oPass), 0);
    check("abort_vec_idx", 32'(oVecIdx), 0);
    wait_cycles(3);
    check("abort_stays_idle", 32'(oBusy), 0);

    start_run(3, 1'b1, 1, 0, 0);
    wait_done(100);
    wait_cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
